lc3_pipe_ctrl: RTL
==================

Name: lc3_pipe_ctrl

Overview:
- Next-generation LC3 pipeline controller: stage enables, branch/JMP resolution with control-hazard hold, register bypass selection and a registered memory-access FSM.
- Sits between fetch/decode/execute/writeback datapath and the data-memory interface.
- Replaces combinational-loop enable logic with one registered FSM plus a shift-register enable chain.
- Adds a parametrised memory timeout and a parametrised branch-resolution hold.

Parameters:
- IW, 16, instruction/IR width; opcode is always IR[IW-1:IW-4].
- MEM_TMO, 15, max cycles waiting on complete_data before mem_timeout asserts; counter width $clog2(MEM_TMO+1).
- BR_HOLD, 1, extra cycles fetch stays held after branch resolution, range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- complete_instr  in  1  IMem read data valid
- complete_data  in  1  DMem access done, one-cycle pulse
- IR  in  IW  instruction in decode
- IR_Exec  in  IW  instruction in execute
- IMem_dout  in  IW  instruction being fetched
- NZP  in  3  branch condition bits of IR_Exec
- psr  in  3  current N/Z/P flags
- enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables
- br_taken  out  1  redirect PC this cycle
- bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  out  1 each  operand forwarding selects
- mem_state  out  2  0=RD, 1=IND, 2=WR, 3=IDLE
- mem_timeout  out  1  sticky error flag

Behaviour:
- Reset (async, any time, mid-access included):
  - mem_state=3.
  - All enables, br_taken, bypass selects and mem_timeout = 0.
  - Timeout counter and hold counter = 0.
  - First posedge after deassert: enable_updatePC=enable_fetch=1.
- Stall:
  - stall = (mem_state!=3) or (mem_state==3 and enable_execute and IR_Exec is LD/LDR/LDI/ST/STR/STI).
- Memory FSM, registered; transitions are taken only with enable_execute=1 in IDLE:
  - IDLE: LD/LDR -> RD; ST/STR -> WR; LDI/STI -> IND.
  - IND + complete_data: LDI -> RD; STI -> WR.
  - RD/WR + complete_data -> IDLE.
  - complete_data while IDLE is ignored.
- Timeout:
  - Counter increments each cycle the FSM is not IDLE and complete_data=0; it clears on every state change.
  - When the count reaches MEM_TMO: mem_timeout=1 (sticky until rst) and the FSM forces IDLE.
- Control hazard:
  - IMem_dout opcode BR(0000)/JMP(1100) with enable_fetch=1 and no control instruction already pending sets ctrl_pending.
  - While ctrl_pending: enable_updatePC=enable_fetch=0.
  - ctrl_pending clears BR_HOLD cycles after the control instruction is in execute with enable_execute=1.
- br_taken:
  - Combinational; asserted only when enable_execute=1 and IR_Exec is BR or JMP.
  - Value = 1 for JMP, |(NZP&psr) for BR.
  - Asserted exactly one cycle per control instruction.
- Enables:
  - enable_updatePC = enable_fetch = !stall && !ctrl_pending && complete_instr.
  - enable_decode <= enable_fetch; enable_execute <= enable_decode; enable_writeback <= enable_execute && !(IR_Exec is BR/JMP/ST/STR/STI).
  - The whole chain freezes (holds its value) while stall=1.
- Bypass selects (combinational, 0 in reset):
  - IR ADD/AND/NOT: src1=IR[8:6]; src2=IR[2:0], checked only if IR[5]=0.
  - IR ST/STI: src2=IR[11:9].
  - IR STR: src1=IR[8:6], src2=IR[11:9].
  - alu_* = src matches IR_Exec[11:9] and IR_Exec is ADD/AND/NOT.
  - mem_* = src matches IR_Exec[11:9] and IR_Exec is LD/LDR/LDI/LEA.
  - All selects = 0 when enable_execute=0.
- Simultaneous events: stall has priority over control hold; a mem op in execute takes precedence over fetching a control instruction.

Optional Feature:
- LC3_CTRL_PERF_EN defined:
  - Adds outputs perf_stall_cycles[15:0] and perf_br_taken[15:0].
  - Both saturating, cleared by rst.
  - perf_stall_cycles counts cycles with stall=1; perf_br_taken counts br_taken pulses.
- LC3_CTRL_PERF_EN undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package lc3_pkg: op_t opcode enum (ADD, AND, NOT, LD, LDR, LDI, LEA, ST, STR, STI, BR, JMP), mem_state_t enum (RD=0, IND=1, WR=2, IDLE=3), is_mem_op/is_alu_op/is_load_op functions.
- One sub-module lc3_bypass_unit: purely combinational forwarding compare, instantiated once.

Test Plan:
- Reset pulse mid-LDI (mem_state=1) -> mem_state=3 immediately, all enables 0; enable_updatePC=1 on first clk after release.
- LD in execute, complete_data after 3 cycles -> mem_state 0 for 3 cycles, fetch held, returns to 3, chain resumes.
- STI with two complete_data pulses -> mem_state 3->1->2->3; enable_writeback=0 for the STI.
- BR NZP=010, psr=010 -> br_taken=1 for one cycle, fetch held until BR_HOLD after resolution; with psr=100, br_taken=0.
- No complete_data for MEM_TMO=15 cycles -> mem_timeout=1 at cycle 15, FSM IDLE, flag sticky until rst.
- ADD R1 in execute, decode ADD R2,R1,R1 -> bypass_alu_1=bypass_alu_2=1; decode ADD R2,R1,#3 -> bypass_alu_2=0.

Source files
------------

// File: rtl/lc3_pipe_ctrl_pkg.sv
// lc3_pkg: shared types and opcode helpers for the LC3 pipeline controller.
// Contents:
//   op_t        - LC3 opcodes that the controller decodes (IR[IW-1:IW-4]).
//   mem_state_t - data-memory access FSM encoding (RD=0, IND=1, WR=2, IDLE=3).
//   is_mem_op / is_alu_op / is_load_op / is_store_op / is_ctrl_op helpers.
package lc3_pkg;

  typedef enum logic [3:0] {
    BR  = 4'b0000,
    ADD = 4'b0001,
    LD  = 4'b0010,
    ST  = 4'b0011,
    AND = 4'b0101,
    LDR = 4'b0110,
    STR = 4'b0111,
    NOT = 4'b1001,
    LDI = 4'b1010,
    STI = 4'b1011,
    JMP = 4'b1100,
    LEA = 4'b1110
  } op_t;

  typedef enum logic [1:0] {
    RD   = 2'd0,
    IND  = 2'd1,
    WR   = 2'd2,
    IDLE = 2'd3
  } mem_state_t;

  // Instructions that need a data-memory access (LEA only forms an address).
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {LD, LDR, LDI, ST, STR, STI};
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {ADD, AND, NOT};
  endfunction

  // Instructions whose destination register is written with a loaded/formed address value.
  function automatic logic is_load_op(input logic [3:0] op);
    return op inside {LD, LDR, LDI, LEA};
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return op inside {ST, STR, STI};
  endfunction

  function automatic logic is_ctrl_op(input logic [3:0] op);
    return op inside {BR, JMP};
  endfunction

endpackage

// File: rtl/lc3_pipe_ctrl_if.sv
// lc3_pipe_ctrl_if: bundle between the LC3 datapath/memory side (master) and the
// pipeline controller (slave).
//   Datapath -> controller: complete_instr, complete_data, IR, IR_Exec, IMem_dout, NZP, psr
//   Controller -> datapath: stage enables, br_taken, bypass selects, mem_state, mem_timeout
//   With LC3_CTRL_PERF_EN defined: perf_stall_cycles, perf_br_taken (controller -> datapath).
// Handshake: complete_instr is a level "IMem data valid" for the word on IMem_dout; a fetch
// is consumed in a cycle only when complete_instr=1 and enable_fetch=1. complete_data is a
// one-cycle "done" pulse for the data access currently tracked by mem_state; it has no
// meaning (and is ignored) while mem_state is IDLE.
interface lc3_pipe_ctrl_if #(parameter int IW = 16);
  logic          complete_instr;
  logic          complete_data;
  logic [IW-1:0] IR;
  logic [IW-1:0] IR_Exec;
  logic [IW-1:0] IMem_dout;
  logic [2:0]    NZP;
  logic [2:0]    psr;
  logic          enable_updatePC;
  logic          enable_fetch;
  logic          enable_decode;
  logic          enable_execute;
  logic          enable_writeback;
  logic          br_taken;
  logic          bypass_alu_1;
  logic          bypass_alu_2;
  logic          bypass_mem_1;
  logic          bypass_mem_2;
  logic [1:0]    mem_state;
  logic          mem_timeout;
`ifdef LC3_CTRL_PERF_EN
  logic [15:0]   perf_stall_cycles;
  logic [15:0]   perf_br_taken;

  modport master (
    output complete_instr, complete_data, IR, IR_Exec, IMem_dout, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    input  mem_state, mem_timeout, perf_stall_cycles, perf_br_taken
  );
  modport slave (
    input  complete_instr, complete_data, IR, IR_Exec, IMem_dout, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    output mem_state, mem_timeout, perf_stall_cycles, perf_br_taken
  );
`else
  modport master (
    output complete_instr, complete_data, IR, IR_Exec, IMem_dout, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    input  mem_state, mem_timeout
  );
  modport slave (
    input  complete_instr, complete_data, IR, IR_Exec, IMem_dout, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
    output mem_state, mem_timeout
  );
`endif
endinterface

// File: rtl/lc3_pipe_ctrl_bypass.sv
// lc3_bypass_unit: combinational operand-forwarding compare between the instruction
// in decode and the instruction in execute.
// Ports:
//   en_exec        - execute stage enable; all selects are 0 when low
//   dec_op, dec_ir - decode opcode and IR[11:0]
//   exe_op, exe_dst- execute opcode and destination IR_Exec[11:9]
//   bypass_alu_1/2 - source 1/2 matches an ADD/AND/NOT destination
//   bypass_mem_1/2 - source 1/2 matches an LD/LDR/LDI/LEA destination
module lc3_bypass_unit
  import lc3_pkg::*;
(
  input  logic        en_exec,
  input  logic [3:0]  dec_op,
  input  logic [11:0] dec_ir,
  input  logic [3:0]  exe_op,
  input  logic [2:0]  exe_dst,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  logic [2:0] src1, src2;
  logic       src1_v, src2_v;
  logic       hit1, hit2;
  logic       unused_bits;

  always_comb begin
    src1   = '0;
    src2   = '0;
    src1_v = 1'b0;
    src2_v = 1'b0;
    case (dec_op)
      ADD, AND, NOT: begin
        src1   = dec_ir[8:6];
        src1_v = 1'b1;
        // IR[5]=1 selects the immediate form (and is always set for NOT).
        src2   = dec_ir[2:0];
        src2_v = !dec_ir[5];
      end
      ST, STI: begin
        src2   = dec_ir[11:9];
        src2_v = 1'b1;
      end
      STR: begin
        src1   = dec_ir[8:6];
        src1_v = 1'b1;
        src2   = dec_ir[11:9];
        src2_v = 1'b1;
      end
      default: ;
    endcase
  end

  assign hit1 = en_exec && src1_v && (src1 == exe_dst);
  assign hit2 = en_exec && src2_v && (src2 == exe_dst);

  assign bypass_alu_1 = hit1 && is_alu_op(exe_op);
  assign bypass_alu_2 = hit2 && is_alu_op(exe_op);
  assign bypass_mem_1 = hit1 && is_load_op(exe_op);
  assign bypass_mem_2 = hit2 && is_load_op(exe_op);

  assign unused_bits = ^dec_ir[4:3];

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: LC3 pipeline controller. Generates stage enables through a registered
// shift chain, holds fetch across BR/JMP resolution, drives operand bypass selects and
// runs the data-memory access FSM with a timeout.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - lc3_pipe_ctrl_if.slave (datapath inputs, enables, br_taken, bypass,
//              mem_state (FSM state, RD=0 IND=1 WR=2 IDLE=3), mem_timeout)
// Parameters: IW (instruction width), MEM_TMO (data access timeout in cycles),
//   BR_HOLD (0..3 extra fetch-hold cycles after branch resolution).
// Optional: LC3_CTRL_PERF_EN adds saturating perf_stall_cycles / perf_br_taken counters.
module lc3_pipe_ctrl
  import lc3_pkg::*;
#(
  parameter int IW      = 16,
  parameter int MEM_TMO = 15,
  parameter int BR_HOLD = 1
) (
  input  logic           clk,
  input  logic           rst,
  lc3_pipe_ctrl_if.slave bus
);

  localparam int TW = $clog2(MEM_TMO + 1);

  logic [3:0]  op_exec, op_fetch;
  mem_state_t  state;
  logic [TW-1:0] tmo_cnt;
  logic        ind_store, acc_done, timeout_q;
  logic        run, ctrl_pending;
  logic [1:0]  hold_cnt;
  logic        en_dec, en_exe, en_wb;
  logic        exec_mem, exec_ctrl, stall, en_fetch, br_taken;
  logic        unused_bits;

  assign op_exec  = bus.IR_Exec[IW-1 -: 4];
  assign op_fetch = bus.IMem_dout[IW-1 -: 4];

  // acc_done marks the cycle right after an access finished (or timed out): the mem op is
  // still in execute, and without this it would immediately start a second access.
  assign exec_mem  = en_exe && is_mem_op(op_exec) && !acc_done;
  assign stall     = (state != IDLE) || exec_mem;
  assign exec_ctrl = en_exe && is_ctrl_op(op_exec);
  assign br_taken  = exec_ctrl && ((op_exec == JMP) || (|(bus.NZP & bus.psr)));
  // run keeps fetch low while in reset and releases it at the first edge afterwards.
  assign en_fetch  = run && !stall && !ctrl_pending && bus.complete_instr;

  // Memory access FSM with timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      ind_store <= 1'b0;
      acc_done  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (exec_mem) begin
            ind_store <= is_store_op(op_exec);
            if (op_exec == LDI || op_exec == STI) state <= IND;
            else if (is_store_op(op_exec))        state <= WR;
            else                                   state <= RD;
          end
        end
        default: begin
          if (bus.complete_data) begin
            tmo_cnt <= '0;
            if (state == IND) begin
              state <= ind_store ? WR : RD;
            end else begin
              state    <= IDLE;
              acc_done <= 1'b1;
            end
          end else if (tmo_cnt == TW'(MEM_TMO - 1)) begin
            // Count reaches MEM_TMO on this edge: abandon the access.
            tmo_cnt   <= '0;
            timeout_q <= 1'b1;
            state     <= IDLE;
            acc_done  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Enable shift chain and control-hazard hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= 1'b0;
      en_dec       <= 1'b0;
      en_exe       <= 1'b0;
      en_wb        <= 1'b0;
      ctrl_pending <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      run <= 1'b1;
      if (!stall) begin
        en_dec <= en_fetch;
        en_exe <= en_dec;
        en_wb  <= en_exe && !(is_ctrl_op(op_exec) || is_store_op(op_exec));
      end
      if (en_fetch && is_ctrl_op(op_fetch)) begin
        ctrl_pending <= 1'b1;
      end else if (ctrl_pending && exec_ctrl && hold_cnt == 2'd0) begin
        if (BR_HOLD == 0) ctrl_pending <= 1'b0;
        else              hold_cnt     <= 2'(BR_HOLD);
      end else if (hold_cnt != 2'd0) begin
        hold_cnt <= hold_cnt - 2'd1;
        if (hold_cnt == 2'd1) ctrl_pending <= 1'b0;
      end
    end
  end

  lc3_bypass_unit u_bypass (
    .en_exec      (en_exe),
    .dec_op       (bus.IR[IW-1 -: 4]),
    .dec_ir       (bus.IR[11:0]),
    .exe_op       (op_exec),
    .exe_dst      (bus.IR_Exec[11:9]),
    .bypass_alu_1 (bus.bypass_alu_1),
    .bypass_alu_2 (bus.bypass_alu_2),
    .bypass_mem_1 (bus.bypass_mem_1),
    .bypass_mem_2 (bus.bypass_mem_2)
  );

`ifdef LC3_CTRL_PERF_EN
  logic [15:0] perf_stall_q, perf_br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_br_q    <= '0;
    end else begin
      if (stall && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
      if (br_taken && perf_br_q != 16'hFFFF) perf_br_q    <= perf_br_q + 16'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_br_taken     = perf_br_q;
`endif

  assign bus.enable_updatePC  = en_fetch;
  assign bus.enable_fetch     = en_fetch;
  assign bus.enable_decode    = en_dec;
  assign bus.enable_execute   = en_exe;
  assign bus.enable_writeback = en_wb;
  assign bus.br_taken         = br_taken;
  assign bus.mem_state        = state;
  assign bus.mem_timeout      = timeout_q;

  assign unused_bits = ^{bus.IMem_dout[IW-5:0], bus.IR_Exec[8:0]};

endmodule
